// File: rtl/spi_master_param_if.sv
// rtl/spi_master_param_if.sv - host-side word interface of the parametrised SPI master
interface spi_master_param_if #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 1,
   parameter int DIV_W  = 8
);
   localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [CS_W-1:0]   cs_sel;
   logic              cpol;
   logic              cpha;
   logic [DIV_W-1:0]  clk_div;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;

   modport master (
      output tx_data, tx_valid, cs_sel, cpol, cpha, clk_div,
      input  tx_ready, rx_data, rx_valid, busy
   );

   modport slave (
      input  tx_data, tx_valid, cs_sel, cpol, cpha, clk_div,
      output tx_ready, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - SPI master with runtime CPOL/CPHA/divider, word width, multi-CS
module spi_master_param #(
   parameter int DATA_W    = 8,
   parameter int NUM_CS    = 1,
   parameter int DIV_W     = 8,
   parameter bit RST_CPOL  = 1'b1,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   spi_master_param_if.slave host,
   output logic              SPI_CLK,
   output logic              SPI_MOSI,
   input  logic              SPI_MISO,
   output logic [NUM_CS-1:0] SPI_CS_N
);
   localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_W + 1);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
   logic                cpha_q, cpha_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [CS_W-1:0]     cs_sel_q, cs_sel_d;
   logic                half_done;
   logic                edge_en;
   logic                edge_lead;

   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return LSB_FIRST ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
      return LSB_FIRST ? (w >> 1) : (w << 1);
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
      return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
   endfunction

   // An out-of-range index matches no bit, so the transfer runs with every CS released.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
      logic [NUM_CS-1:0] cs_n;
      for (int i = 0; i < NUM_CS; i++) cs_n[i] = (sel != CS_W'(i));
      return cs_n;
   endfunction

   assign half_done = (div_cnt_q == '0);
   assign edge_lead = ~edge_cnt_q[0];

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      edge_cnt_d = edge_cnt_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      cpha_d     = cpha_q;
      div_d      = div_q;
      cs_sel_d   = cs_sel_q;
      edge_en    = 1'b0;

      case (state_q)
         IDLE: begin
            sclk_d = host.cpol;
            cs_n_d = '1;
            if (host.tx_valid) begin
               state_d    = SETUP;
               cpha_d     = host.cpha;
               div_d      = host.clk_div;
               cs_sel_d   = host.cs_sel;
               div_cnt_d  = host.clk_div;
               edge_cnt_d = '0;
               cs_n_d     = cs_decode(host.cs_sel);
               if (host.cpha) begin
                  tx_sr_d = host.tx_data;
               end else begin
                  mosi_d  = first_bit(host.tx_data);
                  tx_sr_d = shift_out(host.tx_data);
               end
            end
         end
         SETUP: if (half_done) begin
            state_d = SHIFT;
            edge_en = 1'b1;
         end
         SHIFT: if (half_done) begin
            if (edge_cnt_q == LAST_EDGE) state_d = HOLD;
            else edge_en = 1'b1;
         end
         HOLD: if (half_done) begin
            state_d    = IDLE;
            cs_n_d     = '1;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE) div_cnt_d = half_done ? div_q : div_cnt_q - DIV_W'(1);

      // Sampling happens on the edge whose lead/trail type differs from CPHA; the other edge drives.
      if (edge_en) begin
         sclk_d     = ~sclk_q;
         edge_cnt_d = edge_cnt_q + EDGE_W'(1);
         if (edge_lead ^ cpha_q) begin
            rx_sr_d = shift_in(rx_sr_q, SPI_MISO);
         end else if (edge_cnt_q != LAST_EDGE - EDGE_W'(1)) begin
            mosi_d  = first_bit(tx_sr_q);
            tx_sr_d = shift_out(tx_sr_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         div_cnt_q  <= '0;
         edge_cnt_q <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         sclk_q     <= RST_CPOL;
         mosi_q     <= 1'b0;
         cs_n_q     <= '1;
         cpha_q     <= 1'b0;
         div_q      <= '0;
         cs_sel_q   <= '0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         cpha_q     <= cpha_d;
         div_q      <= div_d;
         cs_sel_q   <= cs_sel_d;
      end
   end

   assign host.tx_ready = (state_q == IDLE) && !rst;
   assign host.rx_data  = rx_data_q;
   assign host.rx_valid = rx_valid_q;
   assign host.busy     = (state_q != IDLE);
   assign SPI_CLK       = sclk_q;
   assign SPI_MOSI      = mosi_q;
   assign SPI_CS_N      = cs_n_q;
endmodule
